// File: rtl/pipeline_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, non-stallable pipeline between NREQ clients.
// A tag shift register follows each issued item so its result is routed back one-hot.
module pipeline_share_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  hold,
  output logic [WIDTH-1:0]      pipe_in,
  input  logic [WIDTH-1:0]      pipe_out,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]   rr_ptr_r;
  logic [WIDTH-1:0] pipe_in_r;
  logic [PIPE_LAT:0] tag_valid_r;
  logic [IDW-1:0]   tag_id_r [PIPE_LAT+1];
  logic             grant_s;
  logic [IDW-1:0]   grant_id_s;
  logic [IDW-1:0]   idx_s;

  // Modulo-NREQ increment that also works when NREQ is not a power of two.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    if (id == IDW'(NREQ-1)) begin
      next_id = {IDW{1'b0}};
    end else begin
      next_id = id + IDW'(1);
    end
  endfunction

  // Round-robin search starting at rr_ptr; hold suppresses every grant.
  always_comb begin
    grant_s    = 1'b0;
    grant_id_s = rr_ptr_r;
    idx_s      = rr_ptr_r;
    for (int j = 0; j < NREQ; j++) begin
      if (!grant_s && !hold && req_valid[idx_s]) begin
        grant_s    = 1'b1;
        grant_id_s = idx_s;
      end else begin
        grant_s    = grant_s;
      end
      idx_s = next_id(idx_s);
    end
  end

  // One-hot grant, forced off while reset is asserted.
  always_comb begin
    req_ready = {NREQ{1'b0}};
    if (grant_s && !reset) begin
      req_ready[grant_id_s] = 1'b1;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
  end

  // Issue register, round-robin pointer and the tag shift register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_r    <= {IDW{1'b0}};
      pipe_in_r   <= {WIDTH{1'b0}};
      tag_valid_r <= {(PIPE_LAT+1){1'b0}};
      for (int i = 0; i <= PIPE_LAT; i++) begin
        tag_id_r[i] <= {IDW{1'b0}};
      end
    end else begin
      tag_valid_r <= {tag_valid_r[PIPE_LAT-1:0], grant_s};
      tag_id_r[0] <= grant_id_s;
      for (int i = 1; i <= PIPE_LAT; i++) begin
        tag_id_r[i] <= tag_id_r[i-1];
      end
      if (grant_s) begin
        pipe_in_r <= req_data[int'(grant_id_s)*WIDTH +: WIDTH];
        rr_ptr_r  <= next_id(grant_id_s);
      end else begin
        pipe_in_r <= {WIDTH{1'b0}};
        rr_ptr_r  <= rr_ptr_r;
      end
    end
  end

  // Route the returning result to the requester named by the last tag stage.
  always_comb begin
    rsp_valid = {NREQ{1'b0}};
    if (tag_valid_r[PIPE_LAT]) begin
      rsp_valid[tag_id_r[PIPE_LAT]] = 1'b1;
    end else begin
      rsp_valid = {NREQ{1'b0}};
    end
  end

  assign pipe_in  = pipe_in_r;
  assign rsp_data = pipe_out;
  assign busy     = |tag_valid_r;

endmodule

// File: tb/tb_pipeline_share_arbiter.sv
// Directed bench for pipeline_share_arbiter; a 3-stage "+3" pipeline model closes the loop.
module tb_pipeline_share_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        hold;
  logic [3:0]  pipe_in;
  logic [3:0]  pipe_out;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_data;
  logic        busy;
  logic [3:0]  pd1, pd2, pd3;
  int          errors;
  int          checks;

  pipeline_share_arbiter #(.NREQ(4), .WIDTH(4), .PIPE_LAT(3)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .hold(hold), .pipe_in(pipe_in), .pipe_out(pipe_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pipeline stand-in: result = operand + 3, visible three edges after pipe_in changes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pd1 <= 4'h0;
      pd2 <= 4'h0;
      pd3 <= 4'h0;
    end else begin
      pd1 <= pipe_in + 4'h3;
      pd2 <= pd1;
      pd3 <= pd2;
    end
  end
  assign pipe_out = pd3;

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    if (i < 0) return 4'b0000;
    return one << i;
  endfunction

  task automatic do_reset;
    reset = 1'b1; req_valid = 4'h0; hold = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 4'h0; req_data = 16'h4321; hold = 1'b0;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (pipe_in !== 4'h0) begin errors++; $display("FAIL reset_pipe_in: got %h expected 0", pipe_in); end
    req_valid = 4'hF; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    reset = 1'b0; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL release_ready: got %b expected 0001", req_ready); end
    @(posedge clock); #1;
    checks++; if (pipe_in !== 4'h1) begin errors++; $display("FAIL first_issue: got %h expected 1", pipe_in); end
    @(posedge clock); #1;
    checks++; if (pipe_in !== 4'h2 || busy !== 1'b1) begin errors++; $display("FAIL second_issue: got %h/%b expected 2/1", pipe_in, busy); end
    #1 reset = 1'b1; #1;
    checks++; if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL async_ready_rsp: got %b/%b expected 0000/0000", req_ready, rsp_valid); end
    checks++; if (busy !== 1'b0 || pipe_in !== 4'h0) begin errors++; $display("FAIL async_busy_pipe: got %b/%h expected 0/0", busy, pipe_in); end
    @(posedge clock); #1;
    reset = 1'b0; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL regrant_req0: got %b expected 0001", req_ready); end
    req_valid = 4'h0;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got %b expected 0", busy); end
  endtask

  task automatic test_single;
    logic [3:0] exp_rsp;
    req_valid = 4'b0100; req_data = 16'h0900; hold = 1'b0; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    @(posedge clock); #1;
    req_valid = 4'h0;
    checks++; if (pipe_in !== 4'h9 || busy !== 1'b1 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_issue: got %h/%b/%b expected 9/1/0000", pipe_in, busy, rsp_valid); end
    for (int c = 1; c <= 4; c++) begin
      @(posedge clock); #1;
      exp_rsp = (c == 3) ? 4'b0100 : 4'b0000;
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL single_rsp c%0d: got %b expected %b", c, rsp_valid, exp_rsp); end
      checks++; if (busy !== (c <= 3)) begin errors++; $display("FAIL single_busy c%0d: got %b expected %b", c, busy, (c <= 3)); end
      if (c == 3) begin
        checks++; if (rsp_data !== 4'hC) begin errors++; $display("FAIL single_data: got %h expected c", rsp_data); end
      end
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] rsp_tab [4] = '{4'hD, 4'hE, 4'hF, 4'h0};
    logic [3:0] exp_rdy, exp_rsp;
    do_reset();
    req_data = 16'hDCBA;
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0; #1;
      exp_rdy = (c < 8) ? oh(c % 4) : 4'b0000;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready c%0d: got %b expected %b", c, req_ready, exp_rdy); end
      @(posedge clock); #1;
      exp_rsp = (c >= 3 && c <= 10) ? oh((c - 3) % 4) : 4'b0000;
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL rr_rsp c%0d: got %b expected %b", c, rsp_valid, exp_rsp); end
      if (c >= 3 && c <= 10) begin
        checks++; if (rsp_data !== rsp_tab[(c - 3) % 4]) begin errors++; $display("FAIL rr_data c%0d: got %h expected %h", c, rsp_data, rsp_tab[(c - 3) % 4]); end
      end
    end
  endtask

  task automatic test_skip;
    int g_tab [10] = '{1, 3, 1, 3, 0, 1, -1, -1, -1, -1};
    int r_tab [10] = '{-1, -1, -1, 1, 3, 1, 3, 0, 1, -1};
    logic [3:0] d_tab [4] = '{4'h8, 4'h9, 4'hA, 4'hB};
    req_data = 16'h8765;
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 3) ? 4'b1010 : (c < 6) ? 4'b1011 : 4'b0000; #1;
      checks++; if (req_ready !== oh(g_tab[c])) begin errors++; $display("FAIL skip_ready c%0d: got %b expected %b", c, req_ready, oh(g_tab[c])); end
      @(posedge clock); #1;
      checks++; if (rsp_valid !== oh(r_tab[c])) begin errors++; $display("FAIL skip_rsp c%0d: got %b expected %b", c, rsp_valid, oh(r_tab[c])); end
      if (r_tab[c] >= 0) begin
        checks++; if (rsp_data !== d_tab[r_tab[c]]) begin errors++; $display("FAIL skip_data c%0d: got %h expected %h", c, rsp_data, d_tab[r_tab[c]]); end
      end
      checks++; if (busy !== (c < 9)) begin errors++; $display("FAIL skip_busy c%0d: got %b expected %b", c, busy, (c < 9)); end
    end
  endtask

  task automatic test_hold;
    int g_tab [13] = '{2, 3, -1, -1, -1, -1, -1, 0, 1, -1, -1, -1, -1};
    int r_tab [13] = '{-1, -1, -1, 2, 3, -1, -1, -1, -1, -1, 0, 1, -1};
    int b_tab [13] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0};
    logic [3:0] d_tab [4] = '{4'h8, 4'h9, 4'hA, 4'hB};
    req_data = 16'h8765;
    for (int c = 0; c < 13; c++) begin
      req_valid = (c < 9) ? 4'hF : 4'h0;
      hold = (c >= 2 && c <= 6); #1;
      checks++; if (req_ready !== oh(g_tab[c])) begin errors++; $display("FAIL hold_ready c%0d: got %b expected %b", c, req_ready, oh(g_tab[c])); end
      @(posedge clock); #1;
      checks++; if (rsp_valid !== oh(r_tab[c])) begin errors++; $display("FAIL hold_rsp c%0d: got %b expected %b", c, rsp_valid, oh(r_tab[c])); end
      if (r_tab[c] >= 0) begin
        checks++; if (rsp_data !== d_tab[r_tab[c]]) begin errors++; $display("FAIL hold_data c%0d: got %h expected %h", c, rsp_data, d_tab[r_tab[c]]); end
      end
      checks++; if (busy !== b_tab[c][0]) begin errors++; $display("FAIL hold_busy c%0d: got %b expected %b", c, busy, b_tab[c][0]); end
    end
    hold = 1'b0;
  endtask

  task automatic test_reset_midflight;
    int g_tab [3] = '{2, 3, 0};
    req_data = 16'h8765;
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'hF; #1;
      checks++; if (req_ready !== oh(g_tab[c])) begin errors++; $display("FAIL mid_ready c%0d: got %b expected %b", c, req_ready, oh(g_tab[c])); end
      @(posedge clock); #1;
    end
    req_valid = 4'h0;
    #1 reset = 1'b1; #1;
    checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0 || pipe_in !== 4'h0) begin errors++; $display("FAIL mid_reset: got %b/%b/%h expected 0000/0/0", rsp_valid, busy, pipe_in); end
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL mid_dropped c%0d: got %b/%b expected 0000/0", c, rsp_valid, busy); end
    end
    test_single();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    req_valid = 4'h0;
    req_data = 16'h0000;
    hold = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_skip();
    test_hold();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
